// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction controller.
// Contents:
//   state_t        controller FSM states
//   OPC_* / OP_*   opcode[15:13] and op[12:11] encodings of the supported instructions
//   VSEL_*         register-file write-back source select
//   ALU_*          ALU operation encodings
package cpu_pkg;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_WR_IMM = 3'd2,
        S_GET_A  = 3'd3,
        S_GET_B  = 3'd4,
        S_ALU    = 3'd5,
        S_WR_REG = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_MDATA  = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
    localparam logic [1:0] VSEL_PC     = 2'b10;
    localparam logic [1:0] VSEL_C      = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction-field splitter.
// Ports:
//   ir      in  16  instruction register contents
//   opcode  out 3   ir[15:13]
//   op      out 2   ir[12:11]
//   rn      out 3   ir[10:8]
//   rd      out 3   ir[7:5]
//   sh      out 2   ir[4:3]
//   rm      out 3   ir[2:0]
//   imm8    out 8   ir[7:0]
//   legal   out 1   1 = one of MOV#, MOV reg, ADD, CMP, AND, MVN
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  opcode,
    output logic [1:0]  op,
    output logic [2:0]  rn,
    output logic [2:0]  rd,
    output logic [1:0]  sh,
    output logic [2:0]  rm,
    output logic [7:0]  imm8,
    output logic        legal
);

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign imm8   = ir[7:0];

    // Every op of the ALU opcode is defined; only op 10 and 00 exist for MOV.
    assign legal = (opcode == OPC_ALU) ||
                   ((opcode == OPC_MOV) && ((op == OP_MOV_IMM) || (op == OP_MOV_REG)));

endmodule

// File: rtl/instr_controller.sv
// Instruction controller: latches an instruction word and sequences the
// datapath strobes for it with a Moore FSM, one instruction per start.
// Handshake: in WAIT (w=1) the controller accepts load (IR <= in) and s
// (start) on any rising edge; both are level-sampled and ignored elsewhere.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in, load, s          instruction word, IR load, start
//   w                    1 = idle in WAIT
//   readnum, writenum    register-file read / write selects
//   write, vsel          register-file write strobe and source select
//   loada, loadb, loadc  A/B/C register loads; loads = status load
//   asel, bsel           A operand forced 0 / B operand = sximm5
//   shift, ALUop         shifter op (IR[4:3]) and ALU op
//   sximm8               IR[7:0]
//   state                current FSM state (debug visibility)
module instr_controller
    import cpu_pkg::*;
#(
    parameter int IW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] in,
    input  logic          load,
    input  logic          s,
    output logic          w,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic [1:0]    vsel,
    output logic          loada,
    output logic          loadb,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic          loadc,
    output logic          loads,
    output logic [7:0]    sximm8,
    output state_t        state
);

    logic [IW-1:0] ir;
    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [2:0]    rn, rd, rm;
    logic [1:0]    sh;
    logic [7:0]    imm8;
    logic          legal;

    instr_decoder u_dec (
        .ir     (ir),
        .opcode (opcode),
        .op     (op),
        .rn     (rn),
        .rd     (rd),
        .sh     (sh),
        .rm     (rm),
        .imm8   (imm8),
        .legal  (legal)
    );

    logic is_mov_imm, is_mov_reg, is_mvn, is_cmp;
    assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    assign is_mvn     = (opcode == OPC_ALU) && (op == OP_MVN);
    assign is_cmp     = (opcode == OPC_ALU) && (op == OP_CMP);

    // State and IR. IR only moves in WAIT, so it is stable during execution;
    // a load coinciding with s means DECODE already sees the new word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (load) ir <= in;
                    if (s) state <= S_DECODE;
                end
                S_DECODE: begin
                    if (!legal)                    state <= S_WAIT;
                    else if (is_mov_imm)           state <= S_WR_IMM;
                    else if (is_mov_reg || is_mvn) state <= S_GET_B;
                    else                           state <= S_GET_A;
                end
                S_WR_IMM: state <= S_WAIT;
                S_GET_A:  state <= S_GET_B;
                S_GET_B:  state <= S_ALU;
                S_ALU:    state <= is_cmp ? S_WAIT : S_WR_REG;
                S_WR_REG: state <= S_WAIT;
                default:  state <= S_WAIT;
            endcase
        end
    end

    // Moore output decode from state and IR only.
    logic write_raw, loada_raw, loadb_raw, loadc_raw, loads_raw;

    always_comb begin
        w         = 1'b0;
        readnum   = '0;
        writenum  = '0;
        write_raw = 1'b0;
        vsel      = VSEL_MDATA;
        loada_raw = 1'b0;
        loadb_raw = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        ALUop     = ALU_ADD;
        loadc_raw = 1'b0;
        loads_raw = 1'b0;
        case (state)
            S_WAIT: w = 1'b1;
            S_WR_IMM: begin
                vsel      = VSEL_SXIMM8;
                writenum  = rn;
                write_raw = 1'b1;
            end
            S_GET_A: begin
                readnum   = rn;
                loada_raw = 1'b1;
            end
            S_GET_B: begin
                readnum   = rm;
                loadb_raw = 1'b1;
            end
            S_ALU: begin
                // MOV reg and MVN pass B alone: A is forced to zero.
                asel  = is_mov_reg || is_mvn;
                ALUop = is_mov_reg ? ALU_ADD : op;
                if (is_cmp) loads_raw = 1'b1;
                else        loadc_raw = 1'b1;
            end
            S_WR_REG: begin
                vsel      = VSEL_C;
                writenum  = rd;
                write_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset suppresses every state-changing strobe immediately, so an
    // interrupted instruction never corrupts registers or status.
    assign write  = write_raw & ~reset;
    assign loada  = loada_raw & ~reset;
    assign loadb  = loadb_raw & ~reset;
    assign loadc  = loadc_raw & ~reset;
    assign loads  = loads_raw & ~reset;

    assign shift  = sh;
    assign sximm8 = imm8;

endmodule
